bdc_chan_ctrl: RTL

BDC_CHAN_CTRL -- requirements
Module: bdc_chan_ctrl

---
 rtl/bdc_chan_ctrl_if.sv | 12 +
 rtl/bdc_chan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bdc_chan_ctrl_if.sv
// Register access bus between the host and the BDC channel controller.
interface bdc_chan_ctrl_if;
    logic [2:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wrtdata;
    logic [7:0] rddata;
    logic       ack;

    modport master (output addr, wr, rd, wrtdata, input rddata, ack);
    modport slave  (input addr, wr, rd, wrtdata, output rddata, ack);
endinterface

// File: rtl/bdc_chan_ctrl.sv
// BDC motor channel controller: register file, PWM/filter prescalers, tach freeze FSM, overcurrent status.
// Optional watchdog on missing duty writes is compiled in with macro BDC_CHAN_WDOG_EN.
module bdc_chan_ctrl #(
    parameter int unsigned FREEZE_TMO  = 255,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    bdc_chan_ctrl_if.slave    bus,
    input  logic [7:0]        countl,
    input  logic [7:0]        counth,
    input  logic              overcurrent,
    output logic              filterce,
    output logic              pwmcntce,
    output logic              pwmldce,
    output logic              freeze,
    output logic              invphase,
    output logic              invertpwm,
    output logic              enablepwm,
    output logic              currentlimit,
    output logic              irq
);

    localparam int unsigned TMO_W = (FREEZE_TMO < 2) ? 1 : $clog2(FREEZE_TMO);
    localparam int unsigned WD_W  = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FREEZE_TMO - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 1);

    localparam logic [2:0] A_DUTY = 3'd0;
    localparam logic [2:0] A_CTRL = 3'd1;
    localparam logic [2:0] A_PDIV = 3'd2;
    localparam logic [2:0] A_FDIV = 3'd3;
    localparam logic [2:0] A_CNTL = 3'd4;
    localparam logic [2:0] A_CNTH = 3'd5;
    localparam logic [2:0] A_STAT = 3'd6;

    typedef enum logic {IDLE, FROZEN} frz_state_t;

    frz_state_t       state, state_nxt;
    logic [TMO_W-1:0] tmo, tmo_nxt;
    logic             snap_ld;
    logic [7:0]       snap_hi;

    logic [2:0] ctrl, ctrl_nxt;
    logic [7:0] pdiv, fdiv, pcnt, fcnt, pcnt_nxt, fcnt_nxt;
    logic [1:0] status, status_nxt, w1c;
    logic       oc_meta;
    logic       ack_q;
    logic [7:0] rddata_q, rd_val;
    logic       wd_trip;

    // Write wins over a simultaneous read; nothing is accepted while in reset
    logic wr_acc, rd_acc;
    assign wr_acc = bus.wr & ~reset;
    assign rd_acc = bus.rd & ~bus.wr & ~reset;

    assign pwmldce   = wr_acc && (bus.addr == A_DUTY);
    assign freeze    = (state == FROZEN);
    assign enablepwm = ctrl[0];
    assign invertpwm = ctrl[1];
    assign invphase  = ctrl[2];
    assign bus.ack    = ack_q;
    assign bus.rddata = rddata_q;

    // Freeze FSM: a low-byte read latches the high byte and holds the tach counter
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        snap_ld   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_acc && bus.addr == A_CNTL) begin
                    state_nxt = FROZEN;
                    tmo_nxt   = '0;
                    snap_ld   = 1'b1;
                end
            end
            FROZEN: begin
                if (rd_acc && bus.addr == A_CNTH) begin
                    state_nxt = IDLE;
                end else if (rd_acc && bus.addr == A_CNTL) begin
                    tmo_nxt = '0;
                    snap_ld = 1'b1;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo + TMO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tmo     <= '0;
            snap_hi <= '0;
        end else begin
            state <= state_nxt;
            tmo   <= tmo_nxt;
            if (snap_ld) snap_hi <= counth;
        end
    end

    // Read mux, sampled in the cycle the read is accepted
    always_comb begin
        rd_val = 8'h00;
        case (bus.addr)
            A_CTRL:  rd_val = {5'b0, ctrl};
            A_PDIV:  rd_val = pdiv;
            A_FDIV:  rd_val = fdiv;
            A_CNTL:  rd_val = countl;
            A_CNTH:  rd_val = (state == FROZEN) ? snap_hi : counth;
            A_STAT:  rd_val = {5'b0, state == FROZEN, status};
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rddata_q <= 8'h00;
        end else begin
            ack_q    <= bus.wr | bus.rd;
            rddata_q <= rd_acc ? rd_val : 8'h00;
        end
    end

    // Prescalers: reload on zero, or immediately on a divisor write
    always_comb begin
        pcnt_nxt = (pcnt == 8'd0) ? pdiv : pcnt - 8'd1;
        fcnt_nxt = (fcnt == 8'd0) ? fdiv : fcnt - 8'd1;
        if (wr_acc && bus.addr == A_PDIV) pcnt_nxt = bus.wrtdata;
        if (wr_acc && bus.addr == A_FDIV) fcnt_nxt = bus.wrtdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pdiv     <= '0;
            fdiv     <= '0;
            pcnt     <= '0;
            fcnt     <= '0;
            pwmcntce <= 1'b0;
            filterce <= 1'b0;
        end else begin
            if (wr_acc && bus.addr == A_PDIV) pdiv <= bus.wrtdata;
            if (wr_acc && bus.addr == A_FDIV) fdiv <= bus.wrtdata;
            pcnt     <= pcnt_nxt;
            fcnt     <= fcnt_nxt;
            pwmcntce <= (pcnt_nxt == 8'd0);
            filterce <= (fcnt_nxt == 8'd0);
        end
    end

`ifdef BDC_CHAN_WDOG_EN
    logic [WD_W-1:0] wd_cnt, wd_nxt;

    // Counts enabled cycles since the last duty write; trips on the last one
    always_comb begin
        wd_trip = 1'b0;
        wd_nxt  = wd_cnt;
        if (!ctrl[0] || (wr_acc && bus.addr == A_DUTY)) begin
            wd_nxt = '0;
        end else if (wd_cnt == WD_LAST) begin
            wd_trip = 1'b1;
            wd_nxt  = '0;
        end else begin
            wd_nxt = wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wd_cnt <= '0;
        else       wd_cnt <= wd_nxt;
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WD_LAST;
    assign wd_trip     = 1'b0;
`endif

    // Control and sticky status; a set condition beats a same-cycle clear
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr_acc && bus.addr == A_CTRL) ctrl_nxt = bus.wrtdata[2:0];
        if (wd_trip) ctrl_nxt[0] = 1'b0;
        w1c = (wr_acc && bus.addr == A_STAT) ? bus.wrtdata[1:0] : 2'b00;
        status_nxt[0] = (status[0] & ~w1c[0]) | currentlimit;
        status_nxt[1] = (status[1] & ~w1c[1]) | wd_trip;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl         <= '0;
            status       <= '0;
            irq          <= 1'b0;
            oc_meta      <= 1'b0;
            currentlimit <= 1'b0;
        end else begin
            ctrl         <= ctrl_nxt;
            status       <= status_nxt;
            irq          <= |status_nxt;
            oc_meta      <= overcurrent;
            currentlimit <= oc_meta;
        end
    end

endmodule
